// File: rtl/sar_adc_scan.sv
// Multi-channel SAR ADC scan controller: settles the analog mux, runs successive-approximation
// trials against an external comparator, optionally averages, and streams results out.
module sar_adc_scan #(
    parameter int unsigned RESOLUTION    = 12,
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned BIT_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned AVG_LOG2      = 0,
    localparam int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic [CHANNELS-1:0]   chan_en_i,
    input  logic                  comp_i,
    output logic [RESOLUTION-1:0] dac_o,
    output logic [CH_W-1:0]       mux_o,
    output logic                  busy_o,
    output logic [RESOLUTION-1:0] data_o,
    output logic [CH_W-1:0]       chan_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > BIT_CYCLES) ? SETTLE_CYCLES : BIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned BIT_W   = $clog2(RESOLUTION);
    localparam int unsigned AVG_W   = AVG_LOG2 + 1;
    localparam int unsigned NCONV   = 1 << AVG_LOG2;
    localparam int unsigned ACC_W   = RESOLUTION + AVG_LOG2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;
    localparam logic [1:0] ST_OUTPUT  = 2'd3;

    logic [1:0]            r_state;
    logic [CHANNELS-1:0]   r_mask;
    logic [CH_W-1:0]       r_mux;
    logic [CNT_W-1:0]      r_cnt;
    logic [BIT_W-1:0]      r_bit;
    logic [RESOLUTION-1:0] r_code;
    logic [AVG_W-1:0]      r_avg;
    logic [ACC_W-1:0]      r_acc;
    logic [RESOLUTION-1:0] r_data;
    logic [CH_W-1:0]       r_chan;

    logic                  w_low_found;
    logic [CH_W-1:0]       w_low_ch;
    logic                  w_next_found;
    logic [CH_W-1:0]       w_next_ch;
    logic [RESOLUTION-1:0] w_trial;
    logic [RESOLUTION-1:0] w_decided;
    logic [ACC_W-1:0]      w_sum;

    // Lowest enabled channel of the live mask, and next enabled channel above mux in the latched one.
    always_comb begin
        w_low_found  = 1'b0;
        w_low_ch     = '0;
        w_next_found = 1'b0;
        w_next_ch    = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (chan_en_i[i]) begin
                w_low_found = 1'b1;
                w_low_ch    = CH_W'(i);
            end
            if (r_mask[i] && (i > int'(r_mux))) begin
                w_next_found = 1'b1;
                w_next_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_trial   = RESOLUTION'(1) << r_bit;
        w_decided = comp_i ? (r_code | w_trial) : r_code;
        w_sum     = r_acc + ACC_W'(w_decided);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_mux   <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_code  <= '0;
            r_avg   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_chan  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i && w_low_found) begin
                        r_mask  <= chan_en_i;
                        r_mux   <= w_low_ch;
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= CNT_W'(BIT_CYCLES - 1);
                        r_bit   <= BIT_W'(RESOLUTION - 1);
                        r_code  <= '0;
                        r_acc   <= '0;
                        r_avg   <= '0;
                        r_state <= ST_CONVERT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CONVERT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_cnt <= CNT_W'(BIT_CYCLES - 1);
                        if (r_bit != '0) begin
                            r_code <= w_decided;
                            r_bit  <= r_bit - BIT_W'(1);
                        end else begin
                            // LSB decided: fold the finished code in, start the next conversion.
                            r_acc  <= w_sum;
                            r_code <= '0;
                            r_bit  <= BIT_W'(RESOLUTION - 1);
                            if (r_avg == AVG_W'(NCONV - 1)) begin
                                r_data  <= RESOLUTION'(w_sum >> AVG_LOG2);
                                r_chan  <= r_mux;
                                r_state <= ST_OUTPUT;
                            end else begin
                                r_avg <= r_avg + AVG_W'(1);
                            end
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (ready_i) begin
                        r_cnt <= CNT_W'(SETTLE_CYCLES - 1);
                        if (w_next_found) begin
                            r_mux   <= w_next_ch;
                            r_state <= ST_SETTLE;
                        end else if (continuous_i && w_low_found) begin
                            r_mask  <= chan_en_i;
                            r_mux   <= w_low_ch;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dac_o   = (r_state == ST_CONVERT) ? (r_code | w_trial) : '0;
    assign mux_o   = r_mux;
    assign busy_o  = (r_state != ST_IDLE);
    assign valid_o = (r_state == ST_OUTPUT);
    assign data_o  = r_data;
    assign chan_o  = r_chan;

endmodule

// File: tb/tb_sar_adc_scan.sv
// Bench for sar_adc_scan: timeline-based reference model checked every cycle, plus directed
// literal scenarios and a randomized scan phase.
module tb_sar_adc_scan;

    localparam int R  = 12;
    localparam int C  = 4;
    localparam int B  = 4;
    localparam int S  = 16;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, cont, ready, comp;
    logic [C-1:0]  en;
    logic [R-1:0]  dac, data;
    logic [CW-1:0] mux, chan;
    logic          busy, valid;
    logic [R-1:0]  vin [C];

    logic          start_a, comp_a;
    logic [R-1:0]  dac_a, data_a, vin_a;
    logic [CW-1:0] mux_a, chan_a;
    logic          busy_a, valid_a;

    // Comparator: analog input sits half an LSB above its code, so a trial equal to it is kept.
    assign comp   = (dac <= vin[mux]);
    assign comp_a = (dac_a <= vin_a);

    sar_adc_scan dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .continuous_i(cont), .chan_en_i(en),
        .comp_i(comp), .dac_o(dac), .mux_o(mux), .busy_o(busy), .data_o(data),
        .chan_o(chan), .valid_o(valid), .ready_i(ready)
    );

    sar_adc_scan #(.AVG_LOG2(2)) dut_avg (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .continuous_i(1'b0),
        .chan_en_i(4'b0001), .comp_i(comp_a), .dac_o(dac_a), .mux_o(mux_a), .busy_o(busy_a),
        .data_o(data_a), .chan_o(chan_a), .valid_o(valid_a), .ready_i(1'b1)
    );

    int checks = 0;
    int errors = 0;
    int q_res[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int lowest(input logic [C-1:0] m);
        for (int i = 0; i < C; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_above(input logic [C-1:0] m, input int cur);
        for (int i = cur + 1; i < C; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Trial code t cycles into a conversion: input's bits above the trial bit, plus the trial bit.
    function automatic int exp_dac(input logic [R-1:0] v, input int t);
        int i;
        int vv;
        i  = R - 1 - t / B;
        vv = int'(v);
        return ((vv >> (i + 1)) << (i + 1)) | (1 << i);
    endfunction

    function automatic int res_at(input int k);
        if (k < q_res.size()) return q_res[k];
        return -1;
    endfunction

    // Model: m_t counts cycles since the current channel's settle began.
    bit           m_busy = 0, m_valid = 0, chk_on = 0;
    int           m_t = 0, m_mux = 0, m_chan = 0, m_data = 0;
    logic [C-1:0] m_mask = '0;

    always @(negedge clk) begin
        int n;
        if (chk_on) begin
            chk("busy", int'(busy), int'(m_busy));
            chk("valid", int'(valid), int'(m_valid));
            chk("mux", int'(mux), m_mux);
            chk("data", int'(data), m_data);
            chk("chan", int'(chan), m_chan);
            chk("dac", int'(dac), (m_busy && !m_valid && m_t >= S) ?
                exp_dac(vin[m_mux], m_t - S) : 0);
            if (valid && ready) q_res.push_back((int'(chan) << 16) | int'(data));
        end
        if (rst) begin
            m_busy = 0; m_valid = 0; m_mux = 0; m_chan = 0; m_data = 0; m_t = 0;
            chk_on = 1;
        end else if (!m_busy) begin
            if (start && en != '0) begin
                m_mask = en; m_mux = lowest(en); m_busy = 1; m_t = 0;
            end
        end else if (m_valid) begin
            if (ready) begin
                m_valid = 0;
                n = next_above(m_mask, m_mux);
                if (n >= 0) begin
                    m_mux = n; m_t = 0;
                end else if (cont && en != '0) begin
                    m_mask = en; m_mux = lowest(en); m_t = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end else begin
            m_t++;
            if (m_t == S + R * B) begin
                m_valid = 1; m_data = int'(vin[m_mux]); m_chan = m_mux;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        chk(name, int'(busy), 0);
    endtask

    initial begin
        int n;
        int k;
        int hold_data, hold_chan, hold_mux;
        rst = 1; start = 0; cont = 0; ready = 1; en = '0; start_a = 0; vin_a = 12'h100;
        for (int i = 0; i < C; i++) vin[i] = '0;
        repeat (3) step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_dac", int'(dac), 0);
        rst = 0;
        step();

        // Single channel, full-rate readout.
        vin[0] = 12'hA5C; en = 4'b0001;
        start = 1; step(); start = 0;
        chk("t1_busy_T1", int'(busy), 1);
        n = 1;
        while (!valid && n < 500) begin
            if (n == S + 1) chk("t1_first_trial", int'(dac), 12'h800);
            step();
            n++;
        end
        chk("t1_valid_cycle", n, 65);
        chk("t1_data", int'(data), 12'hA5C);
        chk("t1_chan", int'(chan), 0);
        step();
        chk("t1_busy_off", int'(busy), 0);

        // Two sparse channels with a full-scale code.
        q_res.delete();
        vin[1] = 12'h123; vin[3] = 12'hFFF; en = 4'b1010;
        start = 1; step(); start = 0;
        chk("t2_first_mux", int'(mux), 1);
        wait_idle("t2_idle", 2000);
        chk("t2_count", q_res.size(), 2);
        chk("t2_res0", res_at(0), (1 << 16) | 12'h123);
        chk("t2_res1", res_at(1), (3 << 16) | 12'hFFF);

        // Averaging instance: alternating 0x100/0x103 conversions truncate to 0x101.
        start_a = 1; step(); start_a = 0;
        n = 1;
        while (!valid_a && n < 1000) begin
            vin_a = (n >= 17 && ((n - 17) / 48) % 2 == 1) ? 12'h103 : 12'h100;
            step();
            n++;
        end
        chk("avg_valid_cycle", n, 209);
        chk("avg_data", int'(data_a), 12'h101);
        chk("avg_chan", int'(chan_a), 0);
        step();
        chk("avg_busy_off", int'(busy_a), 0);

        // Backpressure: result and mux frozen while ready is low.
        q_res.delete();
        vin[2] = 12'h7E1; en = 4'b0100; ready = 0;
        start = 1; step(); start = 0;
        k = 0;
        while (!valid && k < 500) begin
            step();
            k++;
        end
        chk("bp_valid", int'(valid), 1);
        hold_data = int'(data); hold_chan = int'(chan); hold_mux = int'(mux);
        chk("bp_data", hold_data, 12'h7E1);
        repeat (50) begin
            step();
            chk("bp_hold_data", int'(data), hold_data);
            chk("bp_hold_chan", int'(chan), hold_chan);
            chk("bp_hold_mux", int'(mux), hold_mux);
            chk("bp_hold_dac", int'(dac), 0);
        end
        ready = 1;
        step();
        chk("bp_valid_drop", int'(valid), 0);
        chk("bp_one_handshake", q_res.size(), 1);

        // Continuous scan; mask change mid-scan applies only on restart.
        q_res.delete();
        vin[2] = 12'h000; vin[0] = 12'h5A5; vin[1] = 12'h0FF;
        cont = 1; en = 4'b0100;
        start = 1; step(); start = 0;
        repeat (5) step();
        en = 4'b0011;
        k = 0;
        while (q_res.size() < 2 && k < 2000) begin
            step();
            k++;
        end
        cont = 0;
        wait_idle("cont_idle", 2000);
        chk("cont_count", q_res.size(), 3);
        chk("cont_res0", res_at(0), (2 << 16) | 12'h000);
        chk("cont_res1", res_at(1), (0 << 16) | 12'h5A5);
        chk("cont_res2", res_at(2), (1 << 16) | 12'h0FF);

        // Reset during bit 5, then a zero-mask start.
        vin[0] = 12'h9B7; en = 4'b0001;
        start = 1; step(); start = 0;
        for (int i = 1; i < 41; i++) step();
        chk("rst_bit5_dac", int'(dac), 12'h9A0);
        rst = 1; start = 1;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_dac", int'(dac), 0);
        chk("rst_mux", int'(mux), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        rst = 0; en = 4'b0000;
        step();
        chk("zero_mask_busy", int'(busy), 0);
        step();
        chk("zero_mask_busy2", int'(busy), 0);
        start = 0;

        // Randomized scans with random backpressure and mask churn.
        repeat (12) begin
            for (int i = 0; i < C; i++) vin[i] = R'($urandom_range(0, 4095));
            en = C'($urandom_range(0, 15));
            start = 1; step(); start = 0;
            k = 0;
            while (busy && k < 3000) begin
                ready = ($urandom_range(0, 9) < 7);
                en = C'($urandom_range(0, 15));
                step();
                k++;
            end
            chk("rand_idle", int'(busy), 0);
            ready = 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
